// File: rtl/vcr_op_vc_tracker_pkg.sv
// Shared definitions for the output-port VC tracker: OVC state encoding, eligibility
// policies and credit counter sizing. No logic, no latency, no flow control.
package vcr_op_pkg;

  typedef enum logic [1:0] {
    OVC_STATE_IDLE      = 2'd0,
    OVC_STATE_ALLOC     = 2'd1,
    OVC_STATE_TAIL_WAIT = 2'd2
  } ovc_state_e;

  localparam int ELIG_POLICY_TAIL   = 0;
  localparam int ELIG_POLICY_CREDIT = 1;

  // Counter must hold 0..buffer_size inclusive.
  function automatic int cred_width(input int buffer_size);
    return $clog2(buffer_size + 1);
  endfunction

endpackage

// File: rtl/vcr_op_vc_tracker_if.sv
// Allocator <-> output-port tracker bundle; master is the allocator/switch side.
// Pure wiring: no latency, no backpressure.
interface vcr_op_vc_tracker_if #(
  parameter int num_vcs = 4
);
  logic [num_vcs-1:0] vc_gnt_ovc;
  logic               flit_valid;
  logic               flit_head;
  logic               flit_tail;
  logic [num_vcs-1:0] flit_sel_ovc;
  logic               cred_valid;
  logic [num_vcs-1:0] cred_sel_ovc;
  logic [num_vcs-1:0] elig_ovc;
  logic [num_vcs-1:0] free_ovc;
  logic [num_vcs-1:0] empty_ovc;
  logic [num_vcs-1:0] allocated_ovc;
  logic               error;

  modport master (
    output vc_gnt_ovc, flit_valid, flit_head, flit_tail, flit_sel_ovc,
    output cred_valid, cred_sel_ovc,
    input  elig_ovc, free_ovc, empty_ovc, allocated_ovc, error
  );

  modport slave (
    input  vc_gnt_ovc, flit_valid, flit_head, flit_tail, flit_sel_ovc,
    input  cred_valid, cred_sel_ovc,
    output elig_ovc, free_ovc, empty_ovc, allocated_ovc, error
  );
endinterface

// File: rtl/vcr_op_vc_tracker_ovc_state.sv
// One output VC: allocation FSM, saturating credit counter and per-OVC protocol errors.
// Latency: status outputs decode registered state (1 cycle); no backpressure, never stalls.
module vcr_ovc_state
  import vcr_op_pkg::*;
#(
  parameter int buffer_size = 8,
  parameter int elig_policy = ELIG_POLICY_CREDIT,
  parameter int cw          = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic dec,
  input  logic inc,
  input  logic head,
  input  logic tail,
  output logic elig,
  output logic free,
  output logic empty,
  output logic err
);

  localparam logic [cw-1:0] full_cnt = cw'(buffer_size);

  ovc_state_e    state_q, state_nxt;
  logic [cw-1:0] cnt_q, cnt_nxt;
  logic          in_pkt_q, in_pkt_nxt;
  logic          underflow, overflow, fsm_err;
  logic          head_dep, tail_dep;

  always_comb begin
    head_dep   = dec & head;
    tail_dep   = dec & tail;
    underflow  = dec & ~inc & (cnt_q == '0);
    overflow   = inc & ~dec & (cnt_q == full_cnt);
    cnt_nxt    = cnt_q;
    if (dec & ~inc & ~underflow)
      cnt_nxt = cnt_q - cw'(1);
    else if (inc & ~dec & ~overflow)
      cnt_nxt = cnt_q + cw'(1);

    state_nxt  = state_q;
    in_pkt_nxt = in_pkt_q;
    fsm_err    = 1'b0;
    case (state_q)
      OVC_STATE_IDLE: begin
        // A grant colliding with a tail is dropped; the departure itself is the error.
        fsm_err = dec;
        if (gnt & ~tail_dep)
          state_nxt = OVC_STATE_ALLOC;
      end
      OVC_STATE_ALLOC: begin
        fsm_err = gnt | (head_dep & in_pkt_q);
        if (head_dep)
          in_pkt_nxt = 1'b1;
        if (tail_dep) begin
          in_pkt_nxt = 1'b0;
          if (elig_policy == ELIG_POLICY_TAIL || cnt_nxt == full_cnt)
            state_nxt = OVC_STATE_IDLE;
          else
            state_nxt = OVC_STATE_TAIL_WAIT;
        end
      end
      OVC_STATE_TAIL_WAIT: begin
        fsm_err = gnt | dec;
        if (cnt_nxt == full_cnt)
          state_nxt = OVC_STATE_IDLE;
      end
      default: state_nxt = OVC_STATE_IDLE;
    endcase
    err = fsm_err | underflow | overflow;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= OVC_STATE_IDLE;
      cnt_q    <= full_cnt;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      in_pkt_q <= in_pkt_nxt;
    end
  end

  assign elig  = (state_q == OVC_STATE_IDLE);
  assign free  = (cnt_q != '0);
  assign empty = (cnt_q == full_cnt);

endmodule

// File: rtl/vcr_op_vc_tracker.sv
// Output-port OVC tracker: per-OVC allocation/credit state plus sticky protocol error.
// Latency: all outputs visible 1 cycle after the causing input; no backpressure, never stalls.
module vcr_op_vc_tracker
  import vcr_op_pkg::*;
#(
  parameter int num_vcs     = 4,
  parameter int buffer_size = 8,
  parameter int elig_policy = ELIG_POLICY_CREDIT
) (
  input logic                  clk,
  input logic                  reset,
  vcr_op_vc_tracker_if.slave   op
);

  localparam int cw = cred_width(buffer_size);

  logic [num_vcs-1:0] ovc_err;
  logic [num_vcs-1:0] elig;
  logic               sel_err;
  logic               error_q;

  for (genvar v = 0; v < num_vcs; v++) begin : g_ovc
    vcr_ovc_state #(
      .buffer_size (buffer_size),
      .elig_policy (elig_policy),
      .cw          (cw)
    ) u_ovc (
      .clk   (clk),
      .reset (reset),
      .gnt   (op.vc_gnt_ovc[v]),
      .dec   (op.flit_valid & op.flit_sel_ovc[v]),
      .inc   (op.cred_valid & op.cred_sel_ovc[v]),
      .head  (op.flit_head),
      .tail  (op.flit_tail),
      .elig  (elig[v]),
      .free  (op.free_ovc[v]),
      .empty (op.empty_ovc[v]),
      .err   (ovc_err[v])
    );
  end

  // Select vectors are only meaningful while their valid is high.
  assign sel_err = (op.flit_valid & ~$onehot(op.flit_sel_ovc))
                 | (op.cred_valid & ~$onehot(op.cred_sel_ovc))
                 | ~$onehot0(op.vc_gnt_ovc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error_q <= 1'b0;
    else
      error_q <= error_q | sel_err | (|ovc_err);
  end

  assign op.elig_ovc      = elig;
  assign op.allocated_ovc = ~elig;
  assign op.error         = error_q;

endmodule

// File: doc/vcr_op_vc_tracker.md
Name: vcr_op_vc_tracker

Overview:
Output-port controller companion to the VC/switch allocator. Tracks, per output VC of one router output port, allocation state and downstream credit count. Returns eligibility and credit-availability vectors to the allocator: elig_op_ovc slice and the free view per OVC. Consumes allocator VC grants, departing flits, and downstream credit returns. One instance per output port.

Parameters:
num_vcs, 4, output VCs on this port (num_packet_classes*num_vcs_per_class)
buffer_size, 8, downstream flit buffer entries per VC (≥2)
elig_policy, 1, 0 = OVC eligible again right after tail departs; 1 = eligible only after tail departs and all credits are returned
cred_width, clogb(buffer_size+1), credit counter width (localparam)

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-low (asserted at 0)
vc_gnt_ovc  input  num_vcs  one-hot or zero; allocator granted this OVC this cycle
flit_valid  input  1  flit departs on this port this cycle
flit_head  input  1  departing flit is head
flit_tail  input  1  departing flit is tail
flit_sel_ovc  input  num_vcs  one-hot OVC of departing flit
cred_valid  input  1  downstream credit return this cycle
cred_sel_ovc  input  num_vcs  one-hot OVC of returned credit
elig_ovc  output  num_vcs  OVC idle and allocatable
free_ovc  output  num_vcs  OVC has ≥1 credit
empty_ovc  output  num_vcs  credit count == buffer_size
allocated_ovc  output  num_vcs  OVC in ALLOC or TAIL_WAIT
error  output  1  sticky protocol error

Behaviour:
- Per-OVC FSM, 2-bit state: IDLE, ALLOC, TAIL_WAIT. Reset: all IDLE.
- Per-OVC credit counter. Reset value is buffer_size. Next value is cnt - dec + inc, where dec = flit_valid & flit_sel_ovc[v] and inc = cred_valid & cred_sel_ovc[v]. If dec and inc are both set, the count is unchanged.
- Transitions:
  - IDLE -> ALLOC on vc_gnt_ovc[v].
  - ALLOC -> IDLE on a tail departure when elig_policy==0.
  - ALLOC on a tail departure when elig_policy==1: next state is IDLE if next credit count == buffer_size, else TAIL_WAIT.
  - TAIL_WAIT -> IDLE in the cycle after next credit count reaches buffer_size.
- A head+tail single-flit packet in ALLOC follows the tail rule.
- Outputs are registered-state decodes with 1-cycle visibility:
  - elig_ovc[v] = (state==IDLE).
  - allocated_ovc[v] = ~elig_ovc[v].
  - free_ovc[v] = (cnt!=0).
  - empty_ovc[v] = (cnt==buffer_size).
- Reset values: elig_ovc all 1, allocated_ovc 0, free_ovc all 1, empty_ovc all 1, error 0.
- A grant and a tail departure on the same OVC in the same cycle is an error; the grant is ignored.
- error sets and holds until reset on any of:
  - vc_gnt_ovc[v] while state != IDLE;
  - flit departure on an OVC in IDLE or TAIL_WAIT;
  - head flit departing on an OVC already carrying a packet (second head before tail);
  - credit underflow (dec with cnt==0) or overflow (inc without dec with cnt==buffer_size); the counter saturates instead of wrapping;
  - flit_sel_ovc or cred_sel_ovc not one-hot when its valid is set, or vc_gnt_ovc with >1 bit set.
- A flit_sel_ovc value is ignored when flit_valid=0; the same applies to cred_sel_ovc when cred_valid=0.
- Reset asserted mid-packet clears all state immediately (async). Counters return to buffer_size; in-flight credits arriving after deassertion flag overflow.
- Registers update only when reset=1; no clock gating in this block.

Decomposition:
- Shared package vcr_op_pkg: state encoding constants (OVC_STATE_IDLE=0, OVC_STATE_ALLOC=1, OVC_STATE_TAIL_WAIT=2), elig_policy constants (ELIG_POLICY_TAIL=0, ELIG_POLICY_CREDIT=1), credit-width function.
- Sub-module vcr_ovc_state: one OVC's FSM, counter and error terms, instantiated num_vcs times in a generate loop.
- Top level holds the one-hot checks and the sticky error OR-reduce.

Test Plan:
- Reset held low then released -> elig_ovc=4'b1111, free_ovc=4'b1111, empty_ovc=4'b1111, error=0.
- Grant OVC1, send 3 flits (head, body, tail), no credits, policy 1:
  - elig_ovc[1]=0 from cycle after the grant;
  - counter 8->5;
  - state TAIL_WAIT;
  - return 3 credits -> elig_ovc[1]=1 the cycle after the third credit.
- Same traffic, policy 0 -> elig_ovc[1]=1 the cycle after the tail, while empty_ovc[1]=0 until the credits return.
- Send 8 flits on OVC2 with no returns -> free_ovc[2]=0 after the 8th. A flit and a credit on OVC2 in the same cycle -> count stays 0, no error. A 9th flit without a credit -> error=1, count stays 0.
- Grant OVC0 twice without a tail -> error=1 on the second grant. Error stays 1 until reset=0 is pulsed.
- Reset asserted mid-packet on OVC3 -> state IDLE, count 8. A later stray credit on OVC3 -> error=1.
